// File: rtl/pwm_capture.sv
// PWM duty-code recovery: measures period and high time of P, reports J/X/ERR.
// Optional `PWM_CAP_FILTER_EN inserts a 3-tap majority deglitch after the synchronizer.
module pwm_capture #(
  parameter int PERIOD  = 255,
  parameter int TIMEOUT = 510,
  parameter int W       = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         E,
  input  logic         P,
  output logic [W-1:0] J,
  output logic         V,
  output logic         X,
  output logic         ERR
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;

  localparam logic [CW-1:0] C_PER = CW'(PERIOD);
  localparam logic [CW-1:0] C_TO  = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [W-1:0]  J_FS  = '1;

  logic          r_s1;
  logic          r_s2;
  logic          r_pd;
  logic          w_ps;
  logic          w_rise;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_hi;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= P;
      r_s2 <= r_s1;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  logic r_f1;
  logic r_f2;
  logic r_flt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_f1  <= 1'b0;
      r_f2  <= 1'b0;
      r_flt <= 1'b0;
    end else begin
      r_f1  <= r_s2;
      r_f2  <= r_f1;
      r_flt <= (r_s2 & r_f1) | (r_s2 & r_f2) | (r_f1 & r_f2);
    end
  end

  assign w_ps = r_flt;
`else
  assign w_ps = r_s2;
`endif

  always_ff @(posedge CLK) begin
    if (RST) r_pd <= 1'b0;
    else     r_pd <= w_ps;
  end

  assign w_rise = w_ps & ~r_pd;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      J       <= '0;
      V       <= 1'b0;
      X       <= 1'b0;
      ERR     <= 1'b0;
    end else if (!E) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      V       <= 1'b0;
    end else begin
      V <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_ARM;
          r_cnt   <= '0;
          r_hi    <= '0;
        end
        S_ARM, S_MEAS: begin
          if (w_rise) begin
            r_state <= S_MEAS;
            r_cnt   <= C_ONE;
            r_hi    <= C_ONE;
            // The first rise after ARM only opens a period.
            if (r_state == S_MEAS) begin
              if (r_cnt == C_PER) begin
                J   <= W'(C_PER - r_hi);
                X   <= 1'b0;
                ERR <= 1'b0;
                V   <= 1'b1;
              end else begin
                ERR <= 1'b1;
              end
            end
          end else if (r_cnt == C_TO) begin
            r_state <= S_ARM;
            r_cnt   <= '0;
            r_hi    <= '0;
            J       <= w_ps ? '0 : J_FS;
            X       <= ~w_ps;
            ERR     <= 1'b0;
            V       <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
            if (r_state == S_MEAS)
              r_hi <= r_hi + {{(CW-1){1'b0}}, w_ps};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_hi    <= '0;
        end
      endcase
    end
  end

endmodule
